// File: rtl/vga_timing_pattern.sv
// Programmable VGA timing generator with built-in test patterns and an
// external pixel path; sync, de, colour and frame_start share a 2-cycle latency.
module vga_timing_pattern #(
  parameter int         H_SYNC         = 96,
  parameter int         H_BACK         = 48,
  parameter int         H_VALID        = 640,
  parameter int         H_FRONT        = 16,
  parameter int         V_SYNC         = 2,
  parameter int         V_BACK         = 33,
  parameter int         V_VALID        = 480,
  parameter int         V_FRONT        = 10,
  parameter logic       SYNC_POL       = 1'b1,
  parameter int         CELL_LOG2      = 5,
  parameter int         RGB_W          = 12,
  parameter logic [15:0] FRAME_CNT_INIT = 16'h0000
) (
  input  logic             vga_clk,
  input  logic             sys_rst,
  input  logic [2:0]       mode,
  input  logic [RGB_W-1:0] solid_rgb,
  input  logic [RGB_W-1:0] ext_pix_data,
  output logic             pix_req,
  output logic [9:0]       pix_x,
  output logic [9:0]       pix_y,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [RGB_W-1:0] vga_rgb,
  output logic             frame_start,
  output logic [15:0]      frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_VALID / 8;
  localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int CW      = RGB_W / 3;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYN_E = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_S = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_ACT_E = HW'(H_SYNC + H_BACK + H_VALID);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYN_E = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_S = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_ACT_E = VW'(V_SYNC + V_BACK + V_VALID);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
  localparam logic [9:0]    X_LAST  = 10'(H_VALID - 1);
  localparam logic [9:0]    Y_LAST  = 10'(V_VALID - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [BW-1:0] bar_px;
  logic [2:0]    bar_idx;
  logic [2:0]    mode_q;
  logic          h_act, v_act, frame0;

  logic             s1_de, s1_hs, s1_vs, s1_fs;
  logic [9:0]       s1_x, s1_y;
  logic [2:0]       s1_bar;
  logic [RGB_W-1:0] s1_solid;
  logic [RGB_W-1:0] colour;

  // Stage 0: counters and pixel request
  assign h_act  = (h_cnt >= H_ACT_S) && (h_cnt < H_ACT_E);
  assign v_act  = (v_cnt >= V_ACT_S) && (v_cnt < V_ACT_E);
  assign frame0 = (h_cnt == '0) && (v_cnt == '0);

  always_comb begin
    pix_req = h_act && v_act;
    pix_x   = '0;
    pix_y   = '0;
    if (pix_req) begin
      pix_x = 10'(h_cnt - H_ACT_S);
      pix_y = 10'(v_cnt - V_ACT_S);
    end
  end

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      mode_q <= '0;
    end else begin
      if (frame0) mode_q <= mode;
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Bar index tracks the column incrementally, holding at 0 outside active video
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (!h_act) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (bar_px == BAR_LAST) begin
      bar_px  <= '0;
      bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_px <= bar_px + 1'b1;
    end
  end

  // Stage 1
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s1_de    <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_fs    <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_bar   <= '0;
      s1_solid <= '0;
    end else begin
      s1_de    <= pix_req;
      s1_hs    <= h_cnt < H_SYN_E;
      s1_vs    <= v_cnt < V_SYN_E;
      s1_fs    <= frame0;
      s1_x     <= pix_x;
      s1_y     <= pix_y;
      s1_bar   <= bar_idx;
      s1_solid <= solid_rgb;
    end
  end

  // Bar order white, yellow, cyan, green, magenta, red, blue, black
  // falls out of the index bits directly: r=~b1, g=~b2, b=~b0.
  always_comb begin
    colour = '0;
    case (mode_q)
      3'd0: colour = RGB_W'({{CW{~s1_bar[1]}}, {CW{~s1_bar[2]}}, {CW{~s1_bar[0]}}});
      3'd1: colour = (s1_x[CELL_LOG2] ^ s1_y[CELL_LOG2]) ? '1 : '0;
      3'd2: colour = ((s1_x[CELL_LOG2-1:0] == '0) || (s1_y[CELL_LOG2-1:0] == '0) ||
                      (s1_x == X_LAST) || (s1_y == Y_LAST)) ? '1 : '0;
      3'd3: colour = s1_solid;
      3'd4: colour = ext_pix_data;
      default: colour = '0;
    endcase
  end

  // Stage 2: output registers; ext_pix_data arrives one cycle after pix_req
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      vga_rgb     <= '0;
      frame_start <= 1'b0;
      frame_cnt   <= FRAME_CNT_INIT;
    end else begin
      hsync       <= s1_hs ? SYNC_POL : ~SYNC_POL;
      vsync       <= s1_vs ? SYNC_POL : ~SYNC_POL;
      de          <= s1_de;
      vga_rgb     <= s1_de ? colour : '0;
      frame_start <= s1_fs;
      if (s1_fs) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_timing_pattern.sv
// Directed bench for vga_timing_pattern on a reduced 44x14 raster (616 cycles per frame).
module tb_vga_timing_pattern;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  mode = 3'd0;
  logic [11:0] solid_rgb = 12'h000;
  logic [11:0] ext = 12'h000;

  logic        pix_req, hsync, vsync, de, frame_start;
  logic [9:0]  pix_x, pix_y;
  logic [11:0] vga_rgb;
  logic [15:0] frame_cnt;

  logic        u1_pix_req, u1_hsync, u1_vsync, u1_de, u1_frame_start;
  logic [9:0]  u1_pix_x, u1_pix_y;
  logic [11:0] u1_vga_rgb;
  logic [15:0] u1_frame_cnt;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  // External picture source: answers one cycle after the request
  always @(posedge clk) ext <= {pix_y[3:0], pix_x[7:0]};

  vga_timing_pattern #(
    .H_SYNC(4), .H_BACK(4), .H_VALID(32), .H_FRONT(4),
    .V_SYNC(2), .V_BACK(2), .V_VALID(8),  .V_FRONT(2),
    .SYNC_POL(1'b0), .CELL_LOG2(2), .RGB_W(12)
  ) dut (
    .vga_clk(clk), .sys_rst(rst), .mode(mode), .solid_rgb(solid_rgb),
    .ext_pix_data(ext), .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
    .hsync(hsync), .vsync(vsync), .de(de), .vga_rgb(vga_rgb),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  // Second instance: frame counter preloaded near wrap, positive sync
  vga_timing_pattern #(
    .H_SYNC(4), .H_BACK(4), .H_VALID(32), .H_FRONT(4),
    .V_SYNC(2), .V_BACK(2), .V_VALID(8),  .V_FRONT(2),
    .SYNC_POL(1'b1), .CELL_LOG2(2), .RGB_W(12), .FRAME_CNT_INIT(16'hFFFE)
  ) u1 (
    .vga_clk(clk), .sys_rst(rst), .mode(mode), .solid_rgb(solid_rgb),
    .ext_pix_data(ext), .pix_req(u1_pix_req), .pix_x(u1_pix_x), .pix_y(u1_pix_y),
    .hsync(u1_hsync), .vsync(u1_vsync), .de(u1_de), .vga_rgb(u1_vga_rgb),
    .frame_start(u1_frame_start), .frame_cnt(u1_frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
    cyc += n;
  endtask

  // Output at cyc reflects counters at cyc-2; pixel (x,y) of a frame at base+186+44*y+x
  task automatic run_to(input int t);
    if (t > cyc) tick(t - cyc);
  endtask

  initial begin
    int n_de, n_hs, n_vs, n_fs, n_white, n_leak;

    repeat (3) @(negedge clk);
    check("rst_hsync", 32'(hsync), 1);
    check("rst_vsync", 32'(vsync), 1);
    check("rst_de", 32'(de), 0);
    check("rst_rgb", 32'(vga_rgb), 0);
    check("rst_fs", 32'(frame_start), 0);
    check("rst_fcnt", 32'(frame_cnt), 0);
    check("u1_rst_hsync", 32'(u1_hsync), 0);
    check("u1_rst_fcnt", 32'(u1_frame_cnt), 32'hFFFE);

    rst = 1'b0;
    cyc = 0;
    run_to(1);
    check("fs_c1", 32'(frame_start), 0);
    run_to(2);
    check("fs_c2", 32'(frame_start), 1);
    check("fcnt_c2", 32'(frame_cnt), 1);
    check("hsync_c2", 32'(hsync), 0);
    check("vsync_c2", 32'(vsync), 0);
    run_to(3);
    check("fs_c3", 32'(frame_start), 0);
    run_to(5);
    check("hsync_h3", 32'(hsync), 0);
    run_to(6);
    check("hsync_h4", 32'(hsync), 1);
    run_to(89);
    check("vsync_v1_end", 32'(vsync), 0);
    run_to(90);
    check("vsync_v2", 32'(vsync), 1);

    // Frame 0, mode 0 bars, row 0
    run_to(185);
    check("bar_pre_de", 32'(de), 0);
    check("bar_pre_rgb", 32'(vga_rgb), 0);
    run_to(186);
    check("bar_x0_de", 32'(de), 1);
    check("bar_x0", 32'(vga_rgb), 32'hFFF);
    run_to(189);
    check("bar_x3", 32'(vga_rgb), 32'hFFF);
    run_to(190);
    check("bar_x4", 32'(vga_rgb), 32'hFF0);
    run_to(194);
    check("bar_x8", 32'(vga_rgb), 32'h0FF);
    run_to(206);
    check("bar_x20", 32'(vga_rgb), 32'hF00);
    run_to(210);
    check("bar_x24", 32'(vga_rgb), 32'h00F);
    run_to(214);
    check("bar_x28", 32'(vga_rgb), 32'h000);
    check("bar_x28_de", 32'(de), 1);
    run_to(217);
    check("bar_x31_de", 32'(de), 1);
    run_to(218);
    check("bar_post_de", 32'(de), 0);

    // Frame 1 statistics over one full frame of outputs
    run_to(618);
    check("f1_fs", 32'(frame_start), 1);
    check("f1_fcnt", 32'(frame_cnt), 2);
    n_de = 0; n_hs = 0; n_vs = 0; n_fs = 0; n_white = 0; n_leak = 0;
    for (int i = 0; i < 616; i++) begin
      if (de) n_de++;
      if (!hsync) n_hs++;
      if (!vsync) n_vs++;
      if (frame_start) n_fs++;
      if (de && vga_rgb == 12'hFFF) n_white++;
      if (!de && vga_rgb != 12'h000) n_leak++;
      tick(1);
    end
    check("f1_de_count", 32'(n_de), 256);
    check("f1_hsync_count", 32'(n_hs), 56);
    check("f1_vsync_count", 32'(n_vs), 88);
    check("f1_fs_count", 32'(n_fs), 1);
    check("f1_white_count", 32'(n_white), 32);
    check("f1_blank_leak", 32'(n_leak), 0);

    // Mid-frame switch to checkerboard; frame 2 stays bars
    mode = 3'd1;
    run_to(1418);
    check("sw_f2_x0", 32'(vga_rgb), 32'hFFF);
    run_to(1422);
    check("sw_f2_x4", 32'(vga_rgb), 32'hFF0);
    run_to(2034);
    check("chk_f3_x0", 32'(vga_rgb), 32'h000);
    check("chk_f3_de", 32'(de), 1);
    run_to(2038);
    check("chk_f3_x4", 32'(vga_rgb), 32'hFFF);

    // Grid selected exactly on the frame-4 boundary cycle
    run_to(2464);
    mode = 3'd2;
    run_to(2650);
    check("grid_0_0", 32'(vga_rgb), 32'hFFF);
    run_to(2695);
    check("grid_1_1", 32'(vga_rgb), 32'h000);
    run_to(2698);
    check("grid_4_1", 32'(vga_rgb), 32'hFFF);
    run_to(2725);
    check("grid_31_1", 32'(vga_rgb), 32'hFFF);
    run_to(2831);
    check("grid_5_4", 32'(vga_rgb), 32'hFFF);
    run_to(2919);
    check("grid_5_6", 32'(vga_rgb), 32'h000);
    run_to(2963);
    check("grid_5_7", 32'(vga_rgb), 32'hFFF);

    // External source, frame 5
    mode = 3'd4;
    run_to(3397);
    check("ext_pre_de", 32'(de), 0);
    run_to(3398);
    check("ext_0_3", 32'(vga_rgb), 32'h300);
    check("ext_0_3_de", 32'(de), 1);
    run_to(3403);
    check("ext_5_3", 32'(vga_rgb), 32'h305);
    run_to(3429);
    check("ext_31_3", 32'(vga_rgb), 32'h31F);
    run_to(3430);
    check("ext_post_de", 32'(de), 0);
    check("ext_post_rgb", 32'(vga_rgb), 0);

    // Solid colour, frame 6
    mode = 3'd3;
    solid_rgb = 12'hA5C;
    run_to(3980);
    check("solid_10_2", 32'(vga_rgb), 32'hA5C);

    // Reserved mode, frame 7
    mode = 3'd5;
    run_to(4498);
    check("m5_de", 32'(de), 1);
    check("m5_rgb", 32'(vga_rgb), 0);

    // Solid again in frame 8, then reset at counters (20,6)
    mode = 3'd3;
    run_to(5212);
    check("pre_rst_de", 32'(de), 1);
    check("pre_rst_rgb", 32'(vga_rgb), 32'hA5C);
    check("pre_rst_fcnt", 32'(frame_cnt), 9);
    rst = 1'b1;
    #1;
    check("async_de", 32'(de), 0);
    check("async_rgb", 32'(vga_rgb), 0);
    check("async_hsync", 32'(hsync), 1);
    check("async_fcnt", 32'(frame_cnt), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    check("rel_de", 32'(de), 0);
    check("rel_fcnt", 32'(frame_cnt), 0);
    check("u1_rel_fcnt", 32'(u1_frame_cnt), 32'hFFFE);
    run_to(1);
    check("rel_c1_fs", 32'(frame_start), 0);
    check("rel_c1_de", 32'(de), 0);
    run_to(2);
    check("rel_c2_fs", 32'(frame_start), 1);
    check("rel_c2_fcnt", 32'(frame_cnt), 1);
    check("u1_c2_fcnt", 32'(u1_frame_cnt), 32'hFFFF);
    run_to(618);
    check("u1_wrap_fs", 32'(u1_frame_start), 1);
    check("u1_wrap_fcnt", 32'(u1_frame_cnt), 32'h0000);
    check("rel_f1_fcnt", 32'(frame_cnt), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
